reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_STAGES, default 3: number of sequenced reset domains; legal range 1..8.
REQ-002 Parameter HOLD_CYCLES, default 16: minimum all-asserted hold time in clk_i cycles; must be at least 1.
REQ-003 Parameter STAGE_GAP, default 8: cycles between consecutive stage releases; must be at least 1.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth applied to pll_locked_i.
REQ-005 clk_i  input  1  system clock (50 MHz).
REQ-006 rst_ni  input  1  reset; asynchronous assertion, active-low; arrives already deassertion-synchronized to clk_i.
REQ-007 pll_locked_i  input  1  PLL lock flag; asynchronous to clk_i.
REQ-008 sw_rst_req_i  input  1  synchronous single-cycle software reset request (UART command or debounced button).
REQ-009 stage_rst_no  output  N_STAGES  per-domain active-low resets; bit 0 is released first.
REQ-010 done_o  output  1  high when all stages are released.
REQ-011 cause_o  output  2  last reset cause: 0 = POR, 1 = LOCK_LOSS, 2 = SW, 3 = reserved.

Function
REQ-012 pll_locked_i SHALL pass through SYNC_STAGES flops before any use; lock_s below denotes the synchronized value.
REQ-013 The FSM SHALL have four states: HOLD, WAIT_LOCK, RELEASE and RUN.
REQ-014 HOLD: all stages asserted; the hold counter runs from 1 to HOLD_CYCLES.
- On the HOLD_CYCLES-th edge: if lock_s = 1, go to RELEASE; otherwise go to WAIT_LOCK.
REQ-015 WAIT_LOCK: all stages asserted; go to RELEASE on the first edge that samples lock_s = 1.
REQ-016 On the edge entering RELEASE, stage_rst_no[0] SHALL go high.
- Stage i SHALL go high exactly STAGE_GAP*i edges later.
- A released stage SHALL stay high until the next reset cause.
REQ-017 On the edge that releases stage N_STAGES-1, the FSM SHALL enter RUN and done_o SHALL go high.
- For N_STAGES = 1, the edge entering RELEASE goes directly to RUN.
REQ-018 lock_s = 0 in RELEASE or RUN SHALL, on that edge:
- assert all stages;
- clear done_o;
- set cause_o = 1;
- enter HOLD with the counter cleared.
REQ-019 sw_rst_req_i = 1 in any state SHALL, on that edge:
- assert all stages;
- clear done_o;
- set cause_o = 2;
- enter or re-enter HOLD with the counter cleared (a request received in HOLD restarts the hold).
REQ-020 Simultaneous lock loss and sw_rst_req_i SHALL produce cause_o = 2.
REQ-021 Lock loss in HOLD or WAIT_LOCK SHALL NOT restart the counter or change cause_o.
REQ-022 Counters SHALL be $clog2-sized to their maximum value and SHALL saturate or clear, never wrap.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 rst_ni low SHALL, asynchronously:
- set stage_rst_no to all zeros;
- clear done_o;
- set cause_o = 0;
- put the FSM in HOLD with the counters and synchronizer flops cleared.
REQ-025 The first edge with rst_ni high SHALL count as hold cycle 1.

Structure
REQ-026 Package reset_seq_pkg SHALL hold:
- the state enum (HOLD, WAIT_LOCK, RELEASE, RUN);
- the cause encoding constants (CAUSE_POR, CAUSE_LOCK_LOSS, CAUSE_SW).
REQ-027 The lock synchronizer SHALL be a sub-module named bit_sync, parameterized by SYNC_STAGES.
REQ-028 The FSM, hold counter and gap counter SHALL reside in reset_sequencer.

Verification
REQ-029 All scenarios use the defaults.
REQ-030 Scenario 1 (POR): lock held at 1, release rst_ni at edge 0.
- Stage bits go high at edges 16, 24 and 32.
- done_o goes high at edge 32.
- cause_o = 0 throughout.
REQ-031 Scenario 2 (late lock): lock at 0 through HOLD, raised at edge 40.
- FSM sits in WAIT_LOCK.
- stage 0 goes high at edge 42 or 43 (sync latency); later stages follow at +8 and +16.
REQ-032 Scenario 3 (lock loss): drop lock in RUN.
- All stages go low within 3 edges; done_o = 0; cause_o = 1.
- Full sequence repeats after relock.
REQ-033 Scenario 4 (software request): pulse sw_rst_req_i midway through RELEASE (after stage 0 only is high).
- All stages go low next edge; cause_o = 2.
- A second pulse at hold cycle 10 restarts the hold count at 1.
REQ-034 Scenario 5 (simultaneous): pulse sw_rst_req_i on the same edge that lock_s falls.
- cause_o = 2; state HOLD.
REQ-035 Scenario 6 (reset mid-sequence): assert rst_ni mid-RELEASE.
- All outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer:
//   - seq_state_e : sequencer FSM states (HOLD, WAIT_LOCK, RELEASE, RUN)
//   - CAUSE_*     : encodings reported on cause_o for the last reset cause
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR       = 2'd0;
  localparam logic [1:0] CAUSE_LOCK_LOSS = 2'd1;
  localparam logic [1:0] CAUSE_SW        = 2'd2;

endpackage : reset_seq_pkg

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchronizer that brings a single asynchronous bit into the clk_i
// domain. The chain is cleared by the asynchronous active-low reset, so the
// synchronized output reads 0 until SYNC_STAGES edges after the input is high.
// Ports:
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset, clears every flop of the chain
//   d_i     - asynchronous input bit
//   q_o     - synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_flop
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            sync_reg[gi] <= 1'b0;
          end else begin
            sync_reg[gi] <= d_i;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            sync_reg[gi] <= 1'b0;
          end else begin
            sync_reg[gi] <= sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign q_o = sync_reg[SYNC_STAGES-1];

endmodule : bit_sync

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Holds all downstream reset domains asserted for HOLD_CYCLES edges, waits for
// PLL lock, then releases domains one at a time, STAGE_GAP edges apart, lowest
// index first. Lock loss while releasing/running, or a software request in any
// state, re-asserts every domain and restarts the hold.
// Ports:
//   clk_i         - system clock
//   rst_ni        - asynchronous active-low reset (deassertion already synced)
//   pll_locked_i  - PLL lock flag, asynchronous to clk_i
//   sw_rst_req_i  - single-cycle synchronous software reset request
//   stage_rst_no  - per-domain active-low resets, bit 0 released first
//   done_o        - high once every domain is released
//   cause_o       - last reset cause (CAUSE_POR / CAUSE_LOCK_LOSS / CAUSE_SW)
// -----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pll_locked_i,
  input  logic                sw_rst_req_i,
  output logic [N_STAGES-1:0] stage_rst_no,
  output logic                done_o,
  output logic [1:0]          cause_o
);

  // Hold counter must reach HOLD_CYCLES (it saturates there while waiting for
  // lock); the gap counter only ever reaches STAGE_GAP-1 before clearing.
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

  logic lock_s;

  seq_state_e          state_reg,  state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [GAP_W-1:0]    gap_cnt_reg,  gap_cnt_next;
  logic [N_STAGES-1:0] stage_reg,  stage_next;
  logic                done_reg,   done_next;
  logic [1:0]          cause_reg,  cause_next;

  logic                go_release;
  logic [N_STAGES-1:0] stage_shift;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pll_locked_i),
    .q_o    (lock_s)
  );

  // Next release pattern: shift in one more released (high) domain. Written as
  // shift-or so it also works when there is only a single domain.
  assign stage_shift = (stage_reg << 1) | N_STAGES'(1);

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    stage_next    = stage_reg;
    done_next     = done_reg;
    cause_next    = cause_reg;
    go_release    = 1'b0;

    case (state_reg)
      HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          hold_cnt_next = HOLD_MAX;
          if (lock_s) begin
            go_release = 1'b1;
          end else begin
            state_next = WAIT_LOCK;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          go_release = 1'b1;
        end
      end
      RELEASE: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          stage_next   = stage_shift;
          if (stage_shift[N_STAGES-1]) begin
            state_next = RUN;
            done_next  = 1'b1;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      RUN: begin
      end
      default: begin
        state_next = HOLD;
      end
    endcase

    // Stage 0 is released on the very edge that leaves HOLD/WAIT_LOCK; a
    // single-domain configuration is therefore fully released right away.
    if (go_release) begin
      stage_next   = N_STAGES'(1);
      gap_cnt_next = '0;
      if (N_STAGES == 1) begin
        state_next = RUN;
        done_next  = 1'b1;
      end else begin
        state_next = RELEASE;
      end
    end

    // Software request outranks lock loss so a simultaneous event reports SW.
    // Lock loss only matters once release has begun; during HOLD/WAIT_LOCK the
    // domains are already asserted and the hold keeps counting.
    if (sw_rst_req_i) begin
      state_next    = HOLD;
      hold_cnt_next = '0;
      gap_cnt_next  = '0;
      stage_next    = '0;
      done_next     = 1'b0;
      cause_next    = CAUSE_SW;
    end else if (!lock_s && (state_reg == RELEASE || state_reg == RUN)) begin
      state_next    = HOLD;
      hold_cnt_next = '0;
      gap_cnt_next  = '0;
      stage_next    = '0;
      done_next     = 1'b0;
      cause_next    = CAUSE_LOCK_LOSS;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= HOLD;
      hold_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      stage_reg    <= '0;
      done_reg     <= 1'b0;
      cause_reg    <= CAUSE_POR;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      stage_reg    <= stage_next;
      done_reg     <= done_next;
      cause_reg    <= cause_next;
    end
  end

  assign stage_rst_no = stage_reg;
  assign done_o       = done_reg;
  assign cause_o      = cause_reg;

endmodule : reset_sequencer

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer with default parameters. Edges are
// counted from the point where rst_ni (or the last reset event) takes effect;
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic [2:0] stage_rst_n;
  logic       done;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .N_STAGES    (3),
    .HOLD_CYCLES (16),
    .STAGE_GAP   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pll_locked_i (pll_locked),
    .sw_rst_req_i (sw_rst_req),
    .stage_rst_no (stage_rst_n),
    .done_o       (done),
    .cause_o      (cause)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st,
                            input logic dn, input logic [1:0] cs);
    check({tag, " stages"}, 32'(stage_rst_n), 32'(st));
    check({tag, " done"},   32'(done),        32'(dn));
    check({tag, " cause"},  32'(cause),       32'(cs));
    $display("[%0t] %s: stages=%b done=%b cause=%0d", $time, tag, stage_rst_n, done, cause);
  endtask

  // Stage 0 is expected to release on the first-th edge from now; the rest
  // follow 8 and 16 edges later, with done on the last one.
  task automatic seq_check(input string tag, input int first, input logic [1:0] cs);
    tick_n(first - 1);
    check_outs({tag, " before s0"}, 3'b000, 1'b0, cs);
    tick_n(1);
    check_outs({tag, " s0 up"},     3'b001, 1'b0, cs);
    tick_n(7);
    check_outs({tag, " before s1"}, 3'b001, 1'b0, cs);
    tick_n(1);
    check_outs({tag, " s1 up"},     3'b011, 1'b0, cs);
    tick_n(7);
    check_outs({tag, " before s2"}, 3'b011, 1'b0, cs);
    tick_n(1);
    check_outs({tag, " s2 up"},     3'b111, 1'b1, cs);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;

    // Scenario 1: power-on reset with lock already present
    #5;
    check_outs("reset", 3'b000, 1'b0, 2'd0);
    tick_n(2);
    check_outs("reset held", 3'b000, 1'b0, 2'd0);
    rst_n = 1'b1;
    seq_check("por", 16, 2'd0);
    tick_n(5);
    check_outs("por run", 3'b111, 1'b1, 2'd0);

    // Scenario 3: lock loss in RUN, two sync edges then the FSM reacts
    pll_locked = 1'b0;
    tick_n(2);
    check_outs("lockloss sync", 3'b111, 1'b1, 2'd0);
    tick_n(1);
    check_outs("lockloss", 3'b000, 1'b0, 2'd1);
    pll_locked = 1'b1;
    seq_check("relock", 16, 2'd1);

    // Scenario 4: software request from RUN, then midway through RELEASE
    sw_rst_req = 1'b1;
    tick_n(1);
    sw_rst_req = 1'b0;
    check_outs("sw from run", 3'b000, 1'b0, 2'd2);
    tick_n(15);
    check_outs("sw hold", 3'b000, 1'b0, 2'd2);
    tick_n(1);
    check_outs("sw s0 up", 3'b001, 1'b0, 2'd2);
    tick_n(3);
    sw_rst_req = 1'b1;
    tick_n(1);
    sw_rst_req = 1'b0;
    check_outs("sw mid release", 3'b000, 1'b0, 2'd2);
    tick_n(9);
    sw_rst_req = 1'b1;
    tick_n(1);
    sw_rst_req = 1'b0;
    check_outs("sw at hold 10", 3'b000, 1'b0, 2'd2);
    seq_check("sw restart", 16, 2'd2);

    // Scenario 5: software request on the edge that sees lock_s low
    pll_locked = 1'b0;
    tick_n(2);
    sw_rst_req = 1'b1;
    tick_n(1);
    sw_rst_req = 1'b0;
    check_outs("simultaneous", 3'b000, 1'b0, 2'd2);
    pll_locked = 1'b1;
    seq_check("after simul", 16, 2'd2);

    // Scenario 6: asynchronous reset mid-RELEASE
    sw_rst_req = 1'b1;
    tick_n(1);
    sw_rst_req = 1'b0;
    tick_n(16);
    check_outs("pre async s0", 3'b001, 1'b0, 2'd2);
    tick_n(4);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 3'b000, 1'b0, 2'd0);
    pll_locked = 1'b0;
    tick_n(2);
    check_outs("async held", 3'b000, 1'b0, 2'd0);

    // Scenario 2: lock absent through HOLD, raised after edge 40
    rst_n = 1'b1;
    tick_n(39);
    check_outs("wait lock", 3'b000, 1'b0, 2'd0);
    tick_n(1);
    pll_locked = 1'b1;
    seq_check("late lock", 3, 2'd0);
    tick_n(3);
    check_outs("late run", 3'b111, 1'b1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reset_sequencer
